// File: rtl/control_fsm.sv
// control_fsm: multi-cycle CPU control unit decoding opcode and state into datapath controls
module control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        en,
  output logic        PC_sel,
  output logic        RFsel_wr,
  output logic        RFsel_B,
  output logic        RFwr_en,
  output logic        ALUsel_B,
  output logic        MEMwr_en,
  output logic [3:0]  func,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t cur, nxt;
  logic [5:0] op;
  logic is_r, is_andi, is_ori, is_imm, is_b, is_beq, is_bne, is_load, is_store, is_undef;
  logic in_instr, in_exec;
  logic unused_bits;
  assign state = cur;
  assign op = instr[31:26];
  assign unused_bits = ^instr[25:4];
  // opcode classification; li/lui/addi all use ADD with the immediate operand
  always_comb begin
    is_r     = op == 6'b100000;
    is_andi  = op == 6'b110010;
    is_ori   = op == 6'b110011;
    is_imm   = is_andi | is_ori | op == 6'b111000 | op == 6'b111001 | op == 6'b110000;
    is_b     = op == 6'b111111;
    is_beq   = op == 6'b010000;
    is_bne   = op == 6'b010001;
    is_load  = op == 6'b000011 | op == 6'b001111;
    is_store = op == 6'b000111 | op == 6'b011111;
    is_undef = ~(is_r | is_imm | is_b | is_beq | is_bne | is_load | is_store);
  end
  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  // retired-instruction counter, bumps on every PC update
  always_ff @(posedge clk or posedge reset)
    if (reset) instr_count <= 32'd0;
    else if (en) instr_count <= instr_count + 32'd1;
  // next state plus the controls that act only on an instruction's final cycle
  always_comb begin
    nxt = FETCH;
    en = 1'b0;
    PC_sel = 1'b0;
    RFsel_wr = 1'b0;
    RFwr_en = 1'b0;
    MEMwr_en = 1'b0;
    case (cur)
      FETCH: nxt = DECODE;
      DECODE:
        if (is_b | is_undef) begin
          en = 1'b1;
          PC_sel = is_b;
        end else nxt = EXEC;
      EXEC:
        if (is_beq | is_bne) begin
          en = 1'b1;
          PC_sel = is_beq ? zero : ~zero;
        end else nxt = (is_load | is_store) ? MEM : WB;
      MEM:
        if (is_load) begin
          nxt = WB;
          RFsel_wr = 1'b1;
        end else if (is_store) begin
          MEMwr_en = 1'b1;
          en = 1'b1;
        end
      WB: begin
        RFwr_en = 1'b1;
        en = 1'b1;
        RFsel_wr = is_load;
      end
      default: nxt = FETCH;
    endcase
  end
  // operand and ALU selects held steady from their first use to the end of the instruction
  always_comb begin
    in_instr = cur inside {DECODE, EXEC, MEM, WB};
    in_exec  = cur inside {EXEC, MEM, WB};
    RFsel_B  = in_instr & (is_store | is_beq | is_bne);
    ALUsel_B = in_exec & (is_imm | is_load | is_store);
    func = !in_exec ? 4'b0000 : is_r ? instr[3:0] : is_andi ? 4'b0010 : is_ori ? 4'b0011 :
           (is_beq | is_bne) ? 4'b0001 : 4'b0000;
  end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: latency-table model plus directed last-cycle vectors for control_fsm
module tb_control_fsm;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0;
  logic [31:0] instr = 32'd0;
  logic en, PC_sel, RFsel_wr, RFsel_B, RFwr_en, ALUsel_B, MEMwr_en;
  logic [3:0] func;
  logic [2:0] state;
  logic [31:0] instr_count;
  control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .en(en), .PC_sel(PC_sel),
    .RFsel_wr(RFsel_wr), .RFsel_B(RFsel_B), .RFwr_en(RFwr_en), .ALUsel_B(ALUsel_B),
    .MEMwr_en(MEMwr_en), .func(func), .state(state), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0] st;
    logic en, pc, wr, b, rf, ab, mw;
    logic [3:0] fn;
  } out_t;
  typedef struct packed {
    logic [31:0] i;
    logic z;
    logic [2:0] lat;
    logic [13:0] last;
  } vec_t;
  int checks = 0, errors = 0;
  int k = 1;
  logic [31:0] mcount = 32'd0, exp_count = 32'd0;
  out_t mt;
  vec_t tbl [18];
  // expected outputs for cycle k (1 = FETCH) of an instruction, from its class and latency
  function automatic out_t model(logic [31:0] i, logic z, int kk);
    logic [5:0] op;
    logic r, andi, ori, imm, b, beq, bne, ld, st, undef;
    int lat;
    out_t o;
    op = i[31:26];
    r = op == 6'b100000;
    andi = op == 6'b110010;
    ori = op == 6'b110011;
    imm = andi || ori || op == 6'b111000 || op == 6'b111001 || op == 6'b110000;
    b = op == 6'b111111;
    beq = op == 6'b010000;
    bne = op == 6'b010001;
    ld = op == 6'b000011 || op == 6'b001111;
    st = op == 6'b000111 || op == 6'b011111;
    undef = !(r || imm || b || beq || bne || ld || st);
    lat = (b || undef) ? 2 : (beq || bne) ? 3 : ld ? 5 : 4;
    o = '0;
    o.st = (kk == 4 && (ld || st)) ? 3'd3 : kk >= 4 ? 3'd4 : 3'(kk - 1);
    o.en = kk == lat;
    o.pc = o.en && (b || (beq && z) || (bne && !z));
    o.rf = o.en && (r || imm || ld);
    o.mw = o.en && st;
    o.wr = ld && kk >= 4;
    o.b  = (st || beq || bne) && kk >= 2;
    o.ab = (imm || ld || st) && kk >= 3;
    o.fn = kk < 3 ? 4'd0 : r ? i[3:0] : andi ? 4'd2 : ori ? 4'd3 : (beq || bne) ? 4'd1 : 4'd0;
    return o;
  endfunction
  function automatic out_t dut_out();
    return {state, en, PC_sel, RFsel_wr, RFsel_B, RFwr_en, ALUsel_B, MEMwr_en, func};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  // model position within the current instruction and its retired count
  always @(posedge clk or posedge reset)
    if (reset) begin
      k = 1;
      mcount = 32'd0;
    end else begin
      mt = model(instr, zero, k);
      if (mt.en) begin
        k = 1;
        mcount++;
      end else k++;
    end
  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("outputs", 32'(dut_out()), 32'(model(instr, zero, k)));
    chk("instr_count", instr_count, mcount);
  end
  task automatic run(int n);
    instr = tbl[n].i;
    zero = tbl[n].z;
    repeat (int'(tbl[n].lat) - 1) @(posedge clk);
    @(negedge clk);
    chk($sformatf("last_cycle_%0d", n), 32'(dut_out()), 32'(tbl[n].last));
    @(posedge clk);
    #1;
    exp_count++;
    chk($sformatf("count_after_%0d", n), instr_count, exp_count);
    chk($sformatf("fetch_after_%0d", n), 32'(state), 32'd0);
  endtask
  initial begin
    // last-cycle literal: state_en pc wr b rf ab mw_func
    tbl = '{
      '{32'h80000000, 1'b0, 3'd4, 14'b100_1000100_0000},
      '{32'h80000003, 1'b0, 3'd4, 14'b100_1000100_0011},
      '{32'h8123456B, 1'b1, 3'd4, 14'b100_1000100_1011},
      '{32'h3C000000, 1'b0, 3'd5, 14'b100_1010110_0000},
      '{32'h7C000000, 1'b0, 3'd4, 14'b011_1001011_0000},
      '{32'h40000000, 1'b1, 3'd3, 14'b010_1101000_0001},
      '{32'h44000000, 1'b1, 3'd3, 14'b010_1001000_0001},
      '{32'h44000000, 1'b0, 3'd3, 14'b010_1101000_0001},
      '{32'h40000000, 1'b0, 3'd3, 14'b010_1001000_0001},
      '{32'hA8000000, 1'b0, 3'd2, 14'b001_1000000_0000},
      '{32'hFC000000, 1'b0, 3'd2, 14'b001_1100000_0000},
      '{32'hC8000000, 1'b0, 3'd4, 14'b100_1000110_0010},
      '{32'hCC000000, 1'b0, 3'd4, 14'b100_1000110_0011},
      '{32'h0C000000, 1'b1, 3'd5, 14'b100_1010110_0000},
      '{32'h1C000000, 1'b0, 3'd4, 14'b011_1001011_0000},
      '{32'hE0000000, 1'b0, 3'd4, 14'b100_1000110_0000},
      '{32'hE4000000, 1'b0, 3'd4, 14'b100_1000110_0000},
      '{32'hC0000000, 1'b0, 3'd4, 14'b100_1000110_0000}
    };
    #1 reset = 1'b1;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    chk("reset_outputs", 32'(dut_out()), 32'd0);
    #10 reset = 1'b0;
    for (int n = 0; n < 18; n++) run(n);
    instr = 32'h7C000000;
    zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sw_mem_write", 32'({MEMwr_en, en, state}), 32'b11_011);
    #2 reset = 1'b1;
    #1;
    chk("abort_controls", 32'({MEMwr_en, en, RFwr_en, PC_sel}), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_count", instr_count, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    exp_count = 32'd0;
    run(0);
    run(3);
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port instr  input  32  current instruction from IF stage; opcode = instr[31:26], R-type function = instr[3:0].
REQ-004 SHALL have port zero  input  1  ALU zero flag from datapath.
REQ-005 SHALL have port en  output  1  PC write enable; one-cycle pulse on the last cycle of every instruction.
REQ-006 SHALL have port PC_sel  output  1  0 = PC+4, 1 = PC+4+branch offset; valid only while en=1.
REQ-007 SHALL have port RFsel_wr  output  1  RF write data: 0 = ALU_out, 1 = MEM_out.
REQ-008 SHALL have port RFsel_B  output  1  RF read port B address: 0 = instr[15:11], 1 = instr[20:16].
REQ-009 SHALL have port RFwr_en  output  1  RF write enable.
REQ-010 SHALL have port ALUsel_B  output  1  ALU operand B: 0 = RF_B, 1 = immed.
REQ-011 SHALL have port MEMwr_en  output  1  data memory write enable.
REQ-012 SHALL have port func  output  4  ALU op: ADD 0000, SUB 0001, AND 0010, OR 0011; R-type passes instr[3:0].
REQ-013 SHALL have port state  output  3  current state: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4.
REQ-014 SHALL have port instr_count  output  32  retired-instruction counter.

Function
REQ-015 Opcode map SHALL be: R 100000; li 111000; lui 111001; addi 110000; andi 110010; ori 110011; b 111111; beq 010000; bne 010001; lb 000011; lw 001111; sb 000111; sw 011111; any other = undefined.
REQ-016 Outputs SHALL be Moore-style combinational decode of state and instr[31:26]; instr is stable for a whole instruction.
REQ-017 All outputs SHALL be 0 in FETCH and in any state where not stated otherwise.
REQ-018 FETCH SHALL always go to DECODE.
REQ-019 DECODE: b -> en=1, PC_sel=1, next FETCH; undefined -> en=1, PC_sel=0, next FETCH (NOP); all others -> EXEC.
REQ-020 RFsel_B SHALL be 1 for sb, sw, beq, bne from DECODE through last state of the instruction.
REQ-021 ALUsel_B SHALL be 1 for li, lui, addi, andi, ori, lb, lw, sb, sw in EXEC, MEM and WB.
REQ-022 func SHALL be held from EXEC to end of instruction: R -> instr[3:0]; andi -> AND; ori -> OR; beq/bne -> SUB; all others -> ADD (li/lui encodings carry rs=R0).
REQ-023 EXEC: R and immediate-ALU ops -> WB; loads/stores -> MEM; beq -> en=1, PC_sel=zero, next FETCH; bne -> en=1, PC_sel=~zero, next FETCH.
REQ-024 MEM: lb/lw -> next WB with RFsel_wr=1; sb/sw -> MEMwr_en=1, en=1, PC_sel=0, next FETCH.
REQ-025 WB: RFwr_en=1, en=1, PC_sel=0, RFsel_wr=1 for lb/lw else 0, next FETCH.
REQ-026 Latencies SHALL be: b/undefined 2, beq/bne 3, R/immediate/store 4, load 5 cycles.
REQ-027 RFwr_en and MEMwr_en SHALL never be 1 simultaneously and SHALL each last exactly one cycle per instruction.
REQ-028 instr_count SHALL increment by 1 on every clock edge where en=1, wrapping 0xFFFFFFFF -> 0.
REQ-029 States 5-7 SHALL be unreachable; if entered, all outputs 0 and next state FETCH.

Reset
REQ-030 reset=1 SHALL force state=FETCH and instr_count=0 immediately, independent of clk.
REQ-031 While reset=1 all control outputs SHALL be 0; reset mid-instruction SHALL abort it with no RF/MEM write and no PC update.
REQ-032 First rising edge after reset deassertion SHALL move FETCH -> DECODE.

Verification
REQ-033 R add (instr=0x80000000|func 0000) after reset -> states 0,1,2,4; cycle 4: RFwr_en=1, en=1, func=0000, RFsel_wr=0; instr_count=1.
REQ-034 lw (opcode 001111) -> states 0,1,2,3,4; cycle 5: RFwr_en=1, RFsel_wr=1, ALUsel_B=1, en=1; MEMwr_en never 1.
REQ-035 sw (011111) -> states 0,1,2,3; cycle 4: MEMwr_en=1, en=1, RFsel_B=1, RFwr_en=0.
REQ-036 beq with zero=1 -> cycle 3 en=1, PC_sel=1, func=0001; bne with zero=1 -> cycle 3 en=1, PC_sel=0.
REQ-037 Undefined opcode 101010 -> 2 cycles, en=1 PC_sel=0 in DECODE, no writes; b -> 2 cycles PC_sel=1.
REQ-038 reset asserted mid-cycle during MEM of sw -> MEMwr_en and en drop to 0 before next edge, state=0, instr_count=0.
